m_stage_lsu: RTL and testbench

Memory-stage load/store unit that consumes the EX→M pipeline register outputs and turns them into requests on the data-memory port. It formats store data/byte strobes, extracts and sign/zero-extends load data, detects misaligned accesses, and stalls the pipeline while a variable-latency memory transaction is in flight. It sits between the EX/M register and the M/WB register, alongside the hazard unit that consumes `stall_M`.

---
 rtl/m_stage_lsu.sv | 228 ++++++++++++++++++++++
 tb/tb_m_stage_lsu.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_stage_lsu.sv
// Memory-stage load/store unit: formats store data and byte strobes, extracts
// and extends load data, flags misaligned or illegal accesses, and stalls the
// pipeline while a variable-latency data-memory transaction is in flight.
module m_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_result_M,
    input  logic [31:0] rs2_rdata_M,
    input  logic [2:0]  funct3_M,
    input  logic        MemWrite_M,
    input  logic [1:0]  PMAItoReg_M,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic        dmem_req_we,
    output logic [3:0]  dmem_req_wstrb,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        stall_M,
    output logic [31:0] load_data_M,
    output logic        load_data_valid_M,
    output logic        misaligned_M,
    output logic        bus_err_M
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    localparam logic [15:0] TimeoutLimit = TIMEOUT_CYCLES[15:0];

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic        is_load_q, is_load_d;
    logic        timeout_q, timeout_d;
    logic [31:0] load_q, load_d;

    logic        is_store, is_load, access, illegal, unaligned, misaligned, start;
    logic [3:0]  wstrb_fmt;
    logic [31:0] wdata_fmt, shifted, load_fmt;
    logic [15:0] cnt_inc;
    logic        cnt_hit;

    // Decode the incoming access: kind, legality and alignment.
    always_comb begin
        is_store = MemWrite_M;
        is_load  = !MemWrite_M && (PMAItoReg_M == 2'b01);
        access   = is_store || is_load;
        illegal  = 1'b0;
        if (is_store) begin
            illegal = funct3_M[2] || (funct3_M[1:0] == 2'b11);
        end else if (is_load) begin
            illegal = (funct3_M == 3'b011) || (funct3_M == 3'b110) || (funct3_M == 3'b111);
        end
        case (funct3_M[1:0])
            2'b01:   unaligned = alu_result_M[0];
            2'b10:   unaligned = |alu_result_M[1:0];
            default: unaligned = 1'b0;
        endcase
        // Illegal funct3 takes precedence over a misalignment report.
        misaligned = access && !illegal && unaligned;
        start      = access && !illegal && !unaligned;
    end

    // Store strobes and lane-replicated store data.
    always_comb begin
        case (funct3_M[1:0])
            2'b00: begin
                wstrb_fmt = 4'b0001 << alu_result_M[1:0];
                wdata_fmt = {4{rs2_rdata_M[7:0]}};
            end
            2'b01: begin
                wstrb_fmt = 4'b0011 << alu_result_M[1:0];
                wdata_fmt = {2{rs2_rdata_M[15:0]}};
            end
            default: begin
                wstrb_fmt = 4'b1111;
                wdata_fmt = rs2_rdata_M;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension using the captured access.
    always_comb begin
        shifted = dmem_rsp_rdata >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_fmt = {24'h0, shifted[7:0]};
            3'b101:  load_fmt = {16'h0, shifted[15:0]};
            default: load_fmt = dmem_rsp_rdata;
        endcase
    end

    // Timeout counter arithmetic; the limit is hit on the cycle the count would reach it.
    always_comb begin
        cnt_inc = cnt_q + 16'd1;
        cnt_hit = (cnt_inc == TimeoutLimit);
    end

    // State register and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 16'h0;
            addr_q    <= 32'h0;
            we_q      <= 1'b0;
            wstrb_q   <= 4'h0;
            wdata_q   <= 32'h0;
            funct3_q  <= 3'h0;
            lane_q    <= 2'h0;
            is_load_q <= 1'b0;
            timeout_q <= 1'b0;
            load_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wstrb_q   <= wstrb_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            lane_q    <= lane_d;
            is_load_q <= is_load_d;
            timeout_q <= timeout_d;
            load_q    <= load_d;
        end
    end

    // Next-state logic; a handshake or response in the timeout cycle still wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StReq;
            StReq: begin
                if (dmem_req_ready) state_d = we_q ? StDone : StWait;
                else if (cnt_hit)   state_d = StDone;
            end
            StWait: begin
                if (dmem_rsp_valid || cnt_hit) state_d = StDone;
            end
            StDone: state_d = StIdle;
        endcase
    end

    // Datapath next-state: capture the request, count, capture or clear load data.
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        lane_d    = lane_q;
        is_load_d = is_load_q;
        timeout_d = timeout_q;
        load_d    = load_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d     = 16'h0;
                    addr_d    = {alu_result_M[31:2], 2'b00};
                    we_d      = is_store;
                    wstrb_d   = is_store ? wstrb_fmt : 4'h0;
                    wdata_d   = is_store ? wdata_fmt : 32'h0;
                    funct3_d  = funct3_M;
                    lane_d    = alu_result_M[1:0];
                    is_load_d = is_load;
                    timeout_d = 1'b0;
                end
            end
            StReq: begin
                cnt_d = cnt_inc;
                if (!dmem_req_ready && cnt_hit) begin
                    timeout_d = 1'b1;
                    load_d    = 32'h0;
                end
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (dmem_rsp_valid) begin
                    load_d = load_fmt;
                end else if (cnt_hit) begin
                    timeout_d = 1'b1;
                    load_d    = 32'h0;
                end
            end
            StDone: begin
            end
        endcase
    end

    // Outputs; IDLE-state flags are combinational and all flags are gated by reset.
    always_comb begin
        dmem_req_valid    = (state_q == StReq);
        dmem_req_addr     = addr_q;
        dmem_req_we       = we_q;
        dmem_req_wstrb    = wstrb_q;
        dmem_req_wdata    = wdata_q;
        load_data_M       = load_q;
        stall_M           = 1'b0;
        bus_err_M         = 1'b0;
        misaligned_M      = 1'b0;
        load_data_valid_M = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    stall_M      = start;
                    bus_err_M    = access && illegal;
                    misaligned_M = misaligned;
                end
                StReq, StWait: stall_M = 1'b1;
                StDone: begin
                    bus_err_M         = timeout_q;
                    load_data_valid_M = is_load_q && !timeout_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_stage_lsu.sv
// Directed testbench for m_stage_lsu: table of single accesses plus hand
// sequences for reset, timeout, mid-load reset and request backpressure.
module tb_m_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_result_M;
    logic [31:0] rs2_rdata_M;
    logic [2:0]  funct3_M;
    logic        MemWrite_M;
    logic [1:0]  PMAItoReg_M;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [3:0]  dmem_req_wstrb;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        stall_M;
    logic [31:0] load_data_M;
    logic        load_data_valid_M;
    logic        misaligned_M;
    logic        bus_err_M;

    int total = 0;
    int bad   = 0;

    localparam int KOk  = 0;
    localparam int KMis = 1;
    localparam int KErr = 2;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] mem;
        int          kind;
        logic [3:0]  wstrb;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    m_stage_lsu #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alu_result_M      (alu_result_M),
        .rs2_rdata_M       (rs2_rdata_M),
        .funct3_M          (funct3_M),
        .MemWrite_M        (MemWrite_M),
        .PMAItoReg_M       (PMAItoReg_M),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_ready    (dmem_req_ready),
        .dmem_req_addr     (dmem_req_addr),
        .dmem_req_we       (dmem_req_we),
        .dmem_req_wstrb    (dmem_req_wstrb),
        .dmem_req_wdata    (dmem_req_wdata),
        .dmem_rsp_valid    (dmem_rsp_valid),
        .dmem_rsp_rdata    (dmem_rsp_rdata),
        .stall_M           (stall_M),
        .load_data_M       (load_data_M),
        .load_data_valid_M (load_data_valid_M),
        .misaligned_M      (misaligned_M),
        .bus_err_M         (bus_err_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemWrite_M  = 1'b0;
        PMAItoReg_M = 2'b00;
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2);
        MemWrite_M   = st;
        PMAItoReg_M  = st ? 2'b00 : 2'b01;
        funct3_M     = f3;
        alu_result_M = addr;
        rs2_rdata_M  = rs2;
    endtask

    // One access with ready high and a 1-cycle read response.
    task automatic run_vec(input vec_t v, input int idx);
        drive(v.st, v.f3, v.addr, v.rs2);
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = v.mem;
        @(negedge clk);
        if (v.kind != KOk) begin
            chk($sformatf("v%0d_mis", idx), misaligned_M, (v.kind == KMis) ? 1 : 0);
            chk($sformatf("v%0d_err", idx), bus_err_M, (v.kind == KErr) ? 1 : 0);
            chk($sformatf("v%0d_stall", idx), stall_M, 0);
            chk($sformatf("v%0d_noreq", idx), dmem_req_valid, 0);
            step();
            @(negedge clk);
            chk($sformatf("v%0d_noreq2", idx), dmem_req_valid, 0);
            step();
        end else begin
            chk($sformatf("v%0d_stall0", idx), stall_M, 1);
            chk($sformatf("v%0d_req0", idx), dmem_req_valid, 0);
            step();
            @(negedge clk);
            chk($sformatf("v%0d_req1", idx), dmem_req_valid, 1);
            chk($sformatf("v%0d_addr", idx), dmem_req_addr, v.exp_addr);
            chk($sformatf("v%0d_we", idx), dmem_req_we, v.st);
            chk($sformatf("v%0d_wstrb", idx), dmem_req_wstrb, v.wstrb);
            if (v.st) chk($sformatf("v%0d_wdata", idx), dmem_req_wdata, v.exp_data);
            chk($sformatf("v%0d_stall1", idx), stall_M, 1);
            step();
            if (!v.st) begin
                dmem_rsp_valid = 1'b1;
                @(negedge clk);
                chk($sformatf("v%0d_stall2", idx), stall_M, 1);
                chk($sformatf("v%0d_ldv2", idx), load_data_valid_M, 0);
                chk($sformatf("v%0d_req2", idx), dmem_req_valid, 0);
                step();
                dmem_rsp_valid = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("v%0d_stall_done", idx), stall_M, 0);
            chk($sformatf("v%0d_ldv_done", idx), load_data_valid_M, v.st ? 0 : 1);
            chk($sformatf("v%0d_err_done", idx), bus_err_M, 0);
            if (!v.st) chk($sformatf("v%0d_ldata", idx), load_data_M, v.exp_data);
            step();
        end
        idle_inputs();
        @(negedge clk);
        chk($sformatf("v%0d_after_stall", idx), stall_M, 0);
        chk($sformatf("v%0d_after_req", idx), dmem_req_valid, 0);
        step();
    endtask

    initial begin
        //           st  f3      addr          rs2           mem           kind  wstrb    exp_addr      exp_data
        vecs[0]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h1234_56A5, 32'h0, KOk, 4'b1000, 32'h0000_1000, 32'hA5A5_A5A5};
        vecs[1]  = '{1'b1, 3'b001, 32'h0000_1002, 32'hDEAD_BEEF, 32'h0, KOk, 4'b1100, 32'h0000_1000, 32'hBEEF_BEEF};
        vecs[2]  = '{1'b1, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 32'h0, KOk, 4'b1111, 32'h0000_1004, 32'hCAFE_F00D};
        vecs[3]  = '{1'b1, 3'b000, 32'h0000_1001, 32'h0000_005A, 32'h0, KOk, 4'b0010, 32'h0000_1000, 32'h5A5A_5A5A};
        vecs[4]  = '{1'b1, 3'b001, 32'h0000_1000, 32'h0000_1234, 32'h0, KOk, 4'b0011, 32'h0000_1000, 32'h1234_1234};
        vecs[5]  = '{1'b0, 3'b000, 32'h0000_2002, 32'h0, 32'h12F4_5678, KOk, 4'b0000, 32'h0000_2000, 32'hFFFF_FFF4};
        vecs[6]  = '{1'b0, 3'b100, 32'h0000_2002, 32'h0, 32'h12F4_5678, KOk, 4'b0000, 32'h0000_2000, 32'h0000_00F4};
        vecs[7]  = '{1'b0, 3'b001, 32'h0000_2006, 32'h0, 32'h8001_ABCD, KOk, 4'b0000, 32'h0000_2004, 32'hFFFF_8001};
        vecs[8]  = '{1'b0, 3'b101, 32'h0000_2000, 32'h0, 32'h8001_ABCD, KOk, 4'b0000, 32'h0000_2000, 32'h0000_ABCD};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_2008, 32'h0, 32'h89AB_CDEF, KOk, 4'b0000, 32'h0000_2008, 32'h89AB_CDEF};
        vecs[10] = '{1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_7F00, KOk, 4'b0000, 32'h0000_2000, 32'h0000_007F};
        vecs[11] = '{1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h8000_0000, KOk, 4'b0000, 32'h0000_2000, 32'hFFFF_FF80};
        vecs[12] = '{1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, KMis, 4'b0000, 32'h0, 32'h0};
        vecs[13] = '{1'b1, 3'b001, 32'h0000_3003, 32'h0, 32'h0, KMis, 4'b0000, 32'h0, 32'h0};
        vecs[14] = '{1'b0, 3'b001, 32'h0000_3001, 32'h0, 32'h0, KMis, 4'b0000, 32'h0, 32'h0};
        vecs[15] = '{1'b1, 3'b010, 32'h0000_3002, 32'h0, 32'h0, KMis, 4'b0000, 32'h0, 32'h0};
        vecs[16] = '{1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, KErr, 4'b0000, 32'h0, 32'h0};
        vecs[17] = '{1'b1, 3'b100, 32'h0000_3000, 32'h0, 32'h0, KErr, 4'b0000, 32'h0, 32'h0};
        vecs[18] = '{1'b0, 3'b111, 32'h0000_3001, 32'h0, 32'h0, KErr, 4'b0000, 32'h0, 32'h0};
        vecs[19] = '{1'b1, 3'b011, 32'h0000_3000, 32'h0, 32'h0, KErr, 4'b0000, 32'h0, 32'h0};
        vecs[20] = '{1'b0, 3'b101, 32'h0000_3003, 32'h0, 32'h0, KMis, 4'b0000, 32'h0, 32'h0};

        // Reset with a legal store presented: no stall, all outputs at reset values.
        rst_n          = 1'b0;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'h0;
        drive(1'b1, 3'b010, 32'h0000_0000, 32'h1111_1111);
        step();
        @(negedge clk);
        chk("rst_stall", stall_M, 0);
        chk("rst_req", dmem_req_valid, 0);
        chk("rst_addr", dmem_req_addr, 0);
        chk("rst_wstrb", dmem_req_wstrb, 0);
        chk("rst_ldata", load_data_M, 0);
        chk("rst_ldv", load_data_valid_M, 0);
        chk("rst_mis", misaligned_M, 0);
        chk("rst_err", bus_err_M, 0);
        step();
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("post_rst_stall", stall_M, 0);
        chk("post_rst_req", dmem_req_valid, 0);
        step();

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Timeout: ready held low, 4 REQ cycles then DONE with bus error.
        drive(1'b0, 3'b010, 32'h0000_4000, 32'h0);
        dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("to_stall0", stall_M, 1);
        for (int c = 1; c <= 4; c++) begin
            step();
            @(negedge clk);
            chk($sformatf("to_req_c%0d", c), dmem_req_valid, 1);
            chk($sformatf("to_stall_c%0d", c), stall_M, 1);
            chk($sformatf("to_err_c%0d", c), bus_err_M, 0);
        end
        step();
        @(negedge clk);
        chk("to_err", bus_err_M, 1);
        chk("to_stall_done", stall_M, 0);
        chk("to_req_drop", dmem_req_valid, 0);
        chk("to_ldata", load_data_M, 0);
        step();
        idle_inputs();
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("to_late_err", bus_err_M, 0);
        chk("to_late_ldv", load_data_valid_M, 0);
        chk("to_late_req", dmem_req_valid, 0);
        chk("to_late_stall", stall_M, 0);
        step();
        @(negedge clk);
        chk("to_late_ldv2", load_data_valid_M, 0);
        chk("to_late_ldata", load_data_M, 0);
        step();
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b1;

        // Reset in WAIT: load a known value first so the clear is visible.
        run_vec('{1'b0, 3'b010, 32'h0000_2010, 32'h0, 32'h1357_9BDF, KOk, 4'b0000,
                  32'h0000_2010, 32'h1357_9BDF}, 100);
        drive(1'b0, 3'b000, 32'h0000_2004, 32'h0);
        @(negedge clk);
        chk("mr_stall0", stall_M, 1);
        step();
        @(negedge clk);
        chk("mr_req1", dmem_req_valid, 1);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_stall_in_rst", stall_M, 0);
        step();
        @(negedge clk);
        chk("mr_req", dmem_req_valid, 0);
        chk("mr_addr", dmem_req_addr, 0);
        chk("mr_we", dmem_req_we, 0);
        chk("mr_wstrb", dmem_req_wstrb, 0);
        chk("mr_wdata", dmem_req_wdata, 0);
        chk("mr_ldata", load_data_M, 0);
        chk("mr_ldv", load_data_valid_M, 0);
        chk("mr_err", bus_err_M, 0);
        chk("mr_mis", misaligned_M, 0);
        chk("mr_stall", stall_M, 0);
        step();
        rst_n = 1'b1;
        idle_inputs();
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("mr_late_ldv%0d", c), load_data_valid_M, 0);
            chk($sformatf("mr_late_req%0d", c), dmem_req_valid, 0);
            chk($sformatf("mr_late_ldata%0d", c), load_data_M, 0);
            step();
        end
        dmem_rsp_valid = 1'b0;

        // Backpressure: SW with ready low 3 cycles, accepted on cycle 4.
        drive(1'b1, 3'b010, 32'h0000_5008, 32'h0123_4567);
        dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("bp_stall0", stall_M, 1);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) dmem_req_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_req_c%0d", c), dmem_req_valid, 1);
            chk($sformatf("bp_addr_c%0d", c), dmem_req_addr, 32'h0000_5008);
            chk($sformatf("bp_wdata_c%0d", c), dmem_req_wdata, 32'h0123_4567);
            chk($sformatf("bp_wstrb_c%0d", c), dmem_req_wstrb, 4'b1111);
            chk($sformatf("bp_stall_c%0d", c), stall_M, 1);
        end
        step();
        @(negedge clk);
        chk("bp_done_stall", stall_M, 0);
        chk("bp_done_req", dmem_req_valid, 0);
        chk("bp_done_err", bus_err_M, 0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("bp_idle_req", dmem_req_valid, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
